// File: rtl/ahb_pkg.sv
// Shared types, response codes and address validation for the AHB-Lite memory slave.
package ahb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    LAST,
    ERR1,
    ERR2
  } state_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // A transfer is legal only when word-aligned and inside the DEPTH-word window.
  function automatic logic addr_ok(input logic [63:0] haddr, input int unsigned depth);
    return (haddr[1:0] == 2'b00) && (haddr < (64'(depth) << 2));
  endfunction

endpackage

// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite bus signals between an initiator and the memory slave.
interface ahb_slave_mem_if #(
  parameter int AW = 32
);

  logic          HSEL;
  logic [AW-1:0] HADDR;
  logic          HWRITE;
  logic [31:0]   HWDATA;
  logic          HREADY;
  logic [31:0]   HRDATA;
  logic          HREADYOUT;
  logic          HRESP;

  modport slave (
    input  HSEL, HADDR, HWRITE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );

  modport master (
    output HSEL, HADDR, HWRITE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

endinterface

// File: rtl/ahb_mem_array.sv
// DEPTH x 32-bit flop storage, cleared asynchronously, one write and one combinational read port.
module ahb_mem_array #(
  parameter int DEPTH = 16,
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [IW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [IW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  // Storage: every word returns to zero on reset, single word written when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite subordinate: word memory with programmable wait states and a two-cycle ERROR response.
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 1,
  parameter int AW          = 32
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  ahb_slave_mem_if.slave  bus
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CW-1:0] WS_LOAD = CW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_t        state_q;
  logic [IW-1:0] addr_q;
  logic          write_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   hrdata_q;
  logic          hreadyout_q;
  logic          hresp_q;

  logic [AW-1:0] haddr;
  logic          accept;
  logic          addr_good;
  logic [IW-1:0] hidx;
  logic [IW-1:0] raddr;
  logic [31:0]   rdata;
  logic          we;
  logic          fwd;

  assign haddr     = bus.HADDR;
  assign hidx      = haddr[IW+1:2];
  assign addr_good = addr_ok(64'(haddr), DEPTH);
  assign accept    = bus.HSEL && bus.HREADY &&
                     (state_q == IDLE || state_q == LAST || state_q == ERR2);

  // The completing cycle of a write commits HWDATA to the latched word.
  assign we    = (state_q == LAST) && write_q;
  // A zero-wait read accepted now uses the live address; a delayed read uses the latched one.
  assign raddr = accept ? hidx : addr_q;
  // A read that lands on the word being written this very edge must see the new data.
  assign fwd   = we && (addr_q == hidx);

  ahb_mem_array #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clk     (HCLK),
    .rst_n   (HRESETn),
    .we_i    (we),
    .waddr_i (addr_q),
    .wdata_i (bus.HWDATA),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  // Transfer sequencing with registered HREADYOUT/HRESP/HRDATA chosen from the next state.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      write_q     <= 1'b0;
      cnt_q       <= '0;
      hrdata_q    <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      case (state_q)
        WAIT: begin
          if (cnt_q == '0) begin
            state_q     <= LAST;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            if (!write_q) begin
              hrdata_q <= rdata;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ERR1: begin
          state_q     <= ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_ERROR;
        end
        IDLE, LAST, ERR2: begin
          if (accept) begin
            addr_q  <= hidx;
            write_q <= bus.HWRITE;
            if (!addr_good) begin
              state_q     <= ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= HRESP_ERROR;
            end else if (WAIT_STATES > 0) begin
              state_q     <= WAIT;
              cnt_q       <= WS_LOAD;
              hreadyout_q <= 1'b0;
              hresp_q     <= HRESP_OKAY;
            end else begin
              state_q     <= LAST;
              hreadyout_q <= 1'b1;
              hresp_q     <= HRESP_OKAY;
              if (!bus.HWRITE) begin
                hrdata_q <= fwd ? bus.HWDATA : rdata;
              end
            end
          end else begin
            state_q     <= IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
          end
        end
        default: begin
          state_q     <= IDLE;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_OKAY;
        end
      endcase
    end
  end

  assign bus.HRDATA    = hrdata_q;
  assign bus.HREADYOUT = hreadyout_q;
  assign bus.HRESP     = hresp_q;

endmodule
